pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen_if.sv | 34 +++
 rtl/pulse_gen.sv | 203 ++++++++++++++++++++
 tb/tb_pulse_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_if.sv
// Bus and pulse-output bundle for pulse_gen: register strobes, read data and pulse status.
// The master drives the bus strobes. The slave returns registered read data, Pulse_out and Busy.
interface pulse_gen_if;
  logic        Select;
  logic        Read_enable;
  logic        Write_enable;
  logic [2:0]  Address;
  logic [15:0] Write_data_in;
  logic [15:0] Read_data_out;
  logic        Pulse_out;
  logic        Busy;

  modport master (
    output Select,
    output Read_enable,
    output Write_enable,
    output Address,
    output Write_data_in,
    input  Read_data_out,
    input  Pulse_out,
    input  Busy
  );

  modport slave (
    input  Select,
    input  Read_enable,
    input  Write_enable,
    input  Address,
    input  Write_data_in,
    output Read_data_out,
    output Pulse_out,
    output Busy
  );
endinterface

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator with PERIOD/WIDTH/COUNT registers and a status/ctrl word.
// Read data and pulse outputs are registered with 1-cycle latency; the bus has no backpressure.
module pulse_gen (
  input  logic        clock,
  input  logic        reset,
  pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_CTRL   = 3'b000;
  localparam logic [2:0] ADDR_PERIOD = 3'b010;
  localparam logic [2:0] ADDR_WIDTH  = 3'b100;
  localparam logic [2:0] ADDR_COUNT  = 3'b110;

  state_t      state_q, state_d;
  logic [15:0] period_q, width_q, count_q;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] sh_period_q, sh_width_q;
  logic        sh_cont_q;
  logic [15:0] phase_q, phase_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        rd_en, wr_en;
  logic        ctrl_wr, start_req, stop_req, cont_req;
  logic        start_ok;
  logic        status_rd;
  logic        latch_shadow;
  logic        done_set, err_set;
  logic [15:0] width_last, low_last;
  logic [15:0] rd_mux;

  // Read wins over write when both strobes are asserted.
  assign rd_en     = bus.Select & bus.Read_enable;
  assign wr_en     = bus.Select & bus.Write_enable & ~bus.Read_enable;
  assign ctrl_wr   = wr_en & (bus.Address == ADDR_CTRL);
  assign start_req = ctrl_wr &  bus.Write_data_in[0];
  assign stop_req  = ctrl_wr & ~bus.Write_data_in[0];
  assign cont_req  = bus.Write_data_in[1];
  assign status_rd = rd_en & (bus.Address == ADDR_CTRL);

  assign start_ok = (period_q >= 16'd2) &&
                    (width_q != 16'd0) &&
                    (width_q <= period_q - 16'd1) &&
                    ((count_q != 16'd0) || cont_req);

  // Shadows guarantee WIDTH >= 1 and PERIOD > WIDTH, so neither terminal count underflows.
  assign width_last = sh_width_q - 16'd1;
  assign low_last   = sh_period_q - sh_width_q - 16'd1;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    remaining_d  = remaining_q;
    latch_shadow = 1'b0;
    done_set     = 1'b0;
    err_set      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (start_ok) begin
            state_d      = HIGH;
            phase_d      = 16'd0;
            latch_shadow = 1'b1;
            remaining_d  = count_q;
          end else begin
            err_set = 1'b1;
          end
        end
      end

      HIGH: begin
        if (stop_req) begin
          state_d = IDLE;
          phase_d = 16'd0;
        end else if (phase_q == width_last) begin
          state_d = LOW;
          phase_d = 16'd0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      LOW: begin
        if (stop_req) begin
          state_d = IDLE;
          phase_d = 16'd0;
        end else if (phase_q == low_last) begin
          phase_d = 16'd0;
          if (sh_cont_q) begin
            state_d = HIGH;
          end else if (remaining_q <= 16'd1) begin
            remaining_d = 16'd0;
            state_d     = IDLE;
            done_set    = 1'b1;
          end else begin
            remaining_d = remaining_q - 16'd1;
            state_d     = HIGH;
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = 16'd0;
      end
    endcase
  end

  // A completion in the same cycle as a status read must survive the clear.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (status_rd) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (done_set) begin
      done_d = 1'b1;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.Address)
      ADDR_CTRL:   rd_mux = {bus.Busy, 13'b0, err_q, done_q};
      ADDR_PERIOD: rd_mux = period_q;
      ADDR_WIDTH:  rd_mux = width_q;
      ADDR_COUNT:  rd_mux = remaining_q;
      default:     rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 16'd0;
      remaining_q <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_period_q <= 16'd0;
      sh_width_q  <= 16'd0;
      sh_cont_q   <= 1'b0;
    end else if (latch_shadow) begin
      sh_period_q <= period_q;
      sh_width_q  <= width_q;
      sh_cont_q   <= cont_req;
    end
  end

  // Config writes are accepted in every state; a running train only sees the shadows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_q <= 16'd0;
      width_q  <= 16'd0;
      count_q  <= 16'd0;
    end else if (wr_en) begin
      case (bus.Address)
        ADDR_PERIOD: period_q <= bus.Write_data_in;
        ADDR_WIDTH:  width_q  <= bus.Write_data_in;
        ADDR_COUNT:  count_q  <= bus.Write_data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.Read_data_out <= 16'h0000;
      bus.Pulse_out     <= 1'b0;
      bus.Busy          <= 1'b0;
    end else begin
      if (rd_en) begin
        bus.Read_data_out <= rd_mux;
      end
      bus.Pulse_out <= (state_d == HIGH);
      bus.Busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: register reads and per-cycle Busy/Pulse_out against a train model.
module tb_pulse_gen;

  logic clock;
  logic reset;
  pulse_gen_if bus();

  pulse_gen dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  // Train model: value after the k-th edge following the start edge.
  bit m_active = 1'b0;
  bit m_cont   = 1'b0;
  int m_per    = 0;
  int m_wid    = 0;
  int m_cnt    = 0;
  int t0       = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_out(input int k);
    int pos;
    if (!m_active) return 2'b00;
    if (!m_cont && (k >= m_cnt * m_per)) return 2'b00;
    pos = k % m_per;
    return {1'b1, (pos < m_wid)};
  endfunction

  task automatic bus_idle();
    bus.Select       = 1'b0;
    bus.Read_enable  = 1'b0;
    bus.Write_enable = 1'b0;
    bus.Address      = 3'b000;
    bus.Write_data_in = 16'h0000;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.Select        = 1'b1;
    bus.Write_enable  = 1'b1;
    bus.Read_enable   = 1'b0;
    bus.Address       = a;
    bus.Write_data_in = d;
    @(posedge clock); #1;
    bus_idle();
  endtask

  task automatic wr_nosel(input logic [2:0] a, input logic [15:0] d);
    bus.Select        = 1'b0;
    bus.Write_enable  = 1'b1;
    bus.Read_enable   = 1'b1;
    bus.Address       = a;
    bus.Write_data_in = d;
    @(posedge clock); #1;
    bus_idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    bus.Select      = 1'b1;
    bus.Read_enable = 1'b1;
    bus.Address     = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clock); #1;
    bus_idle();
    check(tag_q.pop_front(), bus.Read_data_out, exp_q.pop_front());
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [15:0] d, input logic [15:0] exp, input string tag);
    bus.Select        = 1'b1;
    bus.Read_enable   = 1'b1;
    bus.Write_enable  = 1'b1;
    bus.Address       = a;
    bus.Write_data_in = d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clock); #1;
    bus_idle();
    check(tag_q.pop_front(), bus.Read_data_out, exp_q.pop_front());
  endtask

  task automatic watch(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({14'b0, model_out(cyc - t0)});
      tag_q.push_back($sformatf("%s[k=%0d]", tag, cyc - t0));
      check(tag_q.pop_front(), {14'b0, bus.Busy, bus.Pulse_out}, exp_q.pop_front());
      @(posedge clock); #1;
    end
  endtask

  task automatic go(input int per, input int wid, input int cnt, input bit cont);
    wr(3'b000, {14'b0, cont, 1'b1});
    t0       = cyc;
    m_per    = per;
    m_wid    = wid;
    m_cnt    = cnt;
    m_cont   = cont;
    m_active = 1'b1;
  endtask

  task automatic start_train(input int per, input int wid, input int cnt, input bit cont);
    wr(3'b010, 16'(per));
    wr(3'b100, 16'(wid));
    wr(3'b110, 16'(cnt));
    go(per, wid, cnt, cont);
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rdo", bus.Read_data_out, 16'h0000);
    check("rst_pulse", {15'b0, bus.Pulse_out}, 16'h0000);
    check("rst_busy", {15'b0, bus.Busy}, 16'h0000);
    reset = 1'b0;
    @(posedge clock); #1;

    rd(3'b000, 16'h0000, "rst_status");
    rd(3'b010, 16'h0000, "rst_period");
    rd(3'b100, 16'h0000, "rst_width");
    rd(3'b110, 16'h0000, "rst_remaining");

    // Single three-pulse train.
    wr(3'b010, 16'd4);
    wr(3'b100, 16'd1);
    wr(3'b110, 16'd3);
    rd(3'b010, 16'd4, "cfg_period");
    rd(3'b100, 16'd1, "cfg_width");
    rd(3'b110, 16'd0, "cfg_remaining_idle");
    rd(3'b011, 16'h0000, "odd_offset");
    go(4, 1, 3, 1'b0);
    watch(14, "single");
    rd(3'b000, 16'h0001, "single_done");
    rd(3'b000, 16'h0000, "single_cleared");
    rd(3'b110, 16'h0000, "single_remaining");

    rdwr(3'b010, 16'h0009, 16'd4, "prio_rd");
    rd(3'b010, 16'd4, "prio_no_wr");

    // Invalid configurations.
    wr(3'b010, 16'd3);
    wr(3'b100, 16'd3);
    wr(3'b000, 16'h0001);
    m_active = 1'b0;
    watch(4, "invalid_wid");
    rd(3'b000, 16'h0002, "invalid_err");
    rd(3'b000, 16'h0000, "invalid_cleared");
    wr(3'b010, 16'd4);
    wr(3'b100, 16'd1);
    wr(3'b110, 16'd0);
    wr(3'b000, 16'h0001);
    watch(2, "invalid_cnt");
    rd(3'b000, 16'h0002, "invalid_cnt_err");

    // Continuous mode, ignored restart, deselected stop, real stop.
    start_train(2, 1, 0, 1'b1);
    watch(20, "cont");
    rd(3'b110, 16'h0000, "cont_remaining");
    rd(3'b000, 16'h8000, "cont_status");
    wr(3'b000, 16'h0001);
    wr_nosel(3'b000, 16'h0000);
    watch(4, "cont_after");
    rd(3'b000, 16'h8000, "cont_no_err");
    wr(3'b000, 16'h0000);
    m_active = 1'b0;
    watch(3, "cont_stopped");
    rd(3'b000, 16'h0000, "cont_stop_nodone");

    // Stop mid-train keeps REMAINING.
    start_train(4, 1, 5, 1'b0);
    watch(6, "stop_run");
    wr(3'b000, 16'h0000);
    m_active = 1'b0;
    watch(2, "stop_idle");
    rd(3'b110, 16'd4, "stop_remaining");
    rd(3'b000, 16'h0000, "stop_nodone");

    // Config writes during a train only apply to the next start.
    start_train(8, 4, 2, 1'b0);
    watch(3, "shadow_a");
    wr(3'b010, 16'd2);
    wr(3'b100, 16'd1);
    watch(13, "shadow_b");
    rd(3'b000, 16'h0001, "shadow_done");
    rd(3'b010, 16'd2, "shadow_period");
    go(2, 1, 2, 1'b0);
    watch(6, "shadow_next");
    rd(3'b000, 16'h0001, "shadow_next_done");

    // Status read coinciding with the final LOW edge.
    start_train(4, 1, 1, 1'b0);
    watch(3, "collide_run");
    rd(3'b000, 16'h8000, "collide_rd");
    watch(1, "collide_idle");
    rd(3'b000, 16'h0001, "collide_done");
    rd(3'b000, 16'h0000, "collide_cleared");

    // Asynchronous reset in the HIGH phase.
    start_train(8, 4, 2, 1'b0);
    rd(3'b010, 16'd8, "prerst_period");
    check("prerst_pulse", {15'b0, bus.Pulse_out}, 16'h0001);
    #3;
    reset = 1'b1;
    #1;
    check("arst_pulse", {15'b0, bus.Pulse_out}, 16'h0000);
    check("arst_busy", {15'b0, bus.Busy}, 16'h0000);
    check("arst_rdo", bus.Read_data_out, 16'h0000);
    m_active = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    rd(3'b000, 16'h0000, "arst_status");
    rd(3'b010, 16'h0000, "arst_period");
    rd(3'b100, 16'h0000, "arst_width");
    rd(3'b110, 16'h0000, "arst_remaining");
    start_train(4, 2, 1, 1'b0);
    watch(6, "post_rst");
    rd(3'b000, 16'h0001, "post_rst_done");

    // Maximum period: long HIGH then a single LOW cycle.
    start_train(16'hFFFF, 16'hFFFE, 1, 1'b0);
    watch(1, "maxp_start");
    repeat (65532) @(posedge clock);
    #1;
    watch(3, "maxp_end");
    rd(3'b000, 16'h0001, "maxp_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
